crumb_seq_ctrl: RTL and testbench

//  Sequencer that drives the en/rbit inputs at the head of a daisy chain of crumb cells.
//  - On a start command, streams a burst of pseudo-random bits from a 16-bit LFSR with en high.
//  - Then holds en low for CHAIN_LEN cycles so the last bit can ripple through the chain.
//  - Then reports done. Sits between the top-level control logic and the first crumb instance.

---
 rtl/crumb_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_crumb_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crumb_seq_ctrl.sv
// Burst sequencer for the head of a crumb-cell chain: streams LFSR bits with en high,
// drains the chain for CHAIN_LEN cycles, then reports done. Option: CRUMB_SEQ_CONT_EN.
module crumb_seq_ctrl #(
  parameter int unsigned BW           = 8,
  parameter int unsigned CHAIN_LEN    = 4,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          seed_we,
  input  logic [15:0]   seed,
  input  logic [BW-1:0] burst_len,
  output logic          en_o,
  output logic          rbit_o,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] sent_cnt
);

  localparam int unsigned DW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

`ifdef CRUMB_SEQ_CONT_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          r_state;
  logic [15:0]     r_lfsr;
  logic [BW-1:0]   r_len;
  logic [BW-1:0]   r_cnt;
  logic [DW-1:0]   r_drain;
  logic            r_cont;
  logic            r_en;
  logic            r_rbit;
  logic            r_busy;
  logic            r_done;

  logic            w_fb;
  logic            w_start_ok;
  logic [15:0]     w_seed_val;
  logic [BW-1:0]   w_cnt_inc;
  logic            w_last;

  assign w_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  // A zero-length start is only meaningful as a continuous burst.
  assign w_start_ok = start & ~stop & (ContEn | (burst_len != '0));
  assign w_seed_val = (seed == 16'h0000) ? SEED_DEFAULT : seed;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = ~r_cont & (w_cnt_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_lfsr  <= SEED_DEFAULT;
      r_len   <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_cont  <= 1'b0;
      r_en    <= 1'b0;
      r_rbit  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_en   <= 1'b0;
          r_rbit <= 1'b0;
          r_busy <= 1'b0;
          if (w_start_ok) begin
            r_len   <= burst_len;
            r_cont  <= (burst_len == '0);
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= StRun;
          end else begin
            if (seed_we) r_lfsr <= w_seed_val;
            r_done <= (r_state == StDone);
          end
        end
        StRun: begin
          r_busy <= 1'b1;
          if (stop) begin
            r_en    <= 1'b0;
            r_rbit  <= 1'b0;
            r_drain <= '0;
            r_state <= StDrain;
          end else begin
            r_en   <= 1'b1;
            r_rbit <= r_lfsr[0];
            r_lfsr <= {w_fb, r_lfsr[15:1]};
            // Saturate in counted bursts, wrap in continuous mode.
            if (r_cont || (r_cnt != '1)) r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_drain <= '0;
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          r_en   <= 1'b0;
          r_rbit <= 1'b0;
          r_busy <= 1'b1;
          if (r_drain == DW'(CHAIN_LEN - 1)) begin
            r_state <= StDone;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign en_o     = r_en;
  assign rbit_o   = r_rbit;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_cnt;

endmodule

// File: tb/tb_crumb_seq_ctrl.sv
// Directed self-checking bench for crumb_seq_ctrl (BW=8, CHAIN_LEN=4, seed ACE1).
module tb_crumb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        seed_we = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [7:0]  burst_len = 8'd0;
  logic        en_o, rbit_o, busy, done;
  logic [7:0]  sent_cnt;

  int total = 0;
  int bad = 0;

  crumb_seq_ctrl #(.BW(8), .CHAIN_LEN(4), .SEED_DEFAULT(16'hACE1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .seed_we  (seed_we),
    .seed     (seed),
    .burst_len(burst_len),
    .en_o     (en_o),
    .rbit_o   (rbit_o),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Drive start for one edge; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [7:0] len);
    burst_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({en_o, rbit_o, busy, done, sent_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", {en_o, rbit_o, busy, done, sent_cnt}, 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({en_o, rbit_o, busy, done, sent_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL reset_idle: got %b want %b", {en_o, rbit_o, busy, done, sent_cnt}, 12'h000);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bits = 8'hE1;
    pulse_start(8'd8);
    total++;
    if ({en_o, rbit_o, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL basic_accept: got %b want %b", {en_o, rbit_o, busy, done}, 4'b0000);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, rbit_o, busy, done} !== {1'b1, bits[i], 2'b10}) begin
        bad++;
        $display("FAIL basic_bit[%0d]: got %b want %b", i, {en_o, rbit_o, busy, done},
                 {1'b1, bits[i], 2'b10});
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, rbit_o, busy, done} !== 4'b0010) begin
        bad++;
        $display("FAIL basic_drain[%0d]: got %b want %b", i, {en_o, rbit_o, busy, done}, 4'b0010);
      end
    end
    @(negedge clk);
    total++;
    if ({en_o, busy, done, sent_cnt} !== {3'b001, 8'd8}) begin
      bad++;
      $display("FAIL basic_done: got %b want %b", {en_o, busy, done, sent_cnt}, {3'b001, 8'd8});
    end
  endtask

  task automatic test_seed();
    seed_we = 1'b1;
    seed = 16'h00FF;
    @(negedge clk);
    seed_we = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pulse_start(8'd8);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        total++;
        if ({en_o, rbit_o} !== {1'b1, (b == 0)}) begin
          bad++;
          $display("FAIL seed_burst%0d_bit[%0d]: got %b want %b", b, i, {en_o, rbit_o},
                   {1'b1, (b == 0)});
        end
      end
      repeat (5) @(negedge clk);
      total++;
      if ({busy, done, sent_cnt} !== {2'b01, 8'd8}) begin
        bad++;
        $display("FAIL seed_done%0d: got %b want %b", b, {busy, done, sent_cnt}, {2'b01, 8'd8});
      end
    end
  endtask

  task automatic test_stop();
    pulse_start(8'd20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, busy, done} !== 3'b110) begin
        bad++;
        $display("FAIL stop_run[%0d]: got %b want %b", i, {en_o, busy, done}, 3'b110);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({en_o, rbit_o, busy, done, sent_cnt} !== {4'b0010, 8'd5}) begin
      bad++;
      $display("FAIL stop_halt: got %b want %b", {en_o, rbit_o, busy, done, sent_cnt},
               {4'b0010, 8'd5});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, busy, done} !== 3'b010) begin
        bad++;
        $display("FAIL stop_drain[%0d]: got %b want %b", i, {en_o, busy, done}, 3'b010);
      end
    end
    @(negedge clk);
    total++;
    if ({en_o, busy, done, sent_cnt} !== {3'b001, 8'd5}) begin
      bad++;
      $display("FAIL stop_done: got %b want %b", {en_o, busy, done, sent_cnt}, {3'b001, 8'd5});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits = 8'hE1;
    pulse_start(8'd8);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({en_o, rbit_o, busy, done, sent_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_async: got %b want %b", {en_o, rbit_o, busy, done, sent_cnt},
               12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(8'd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, rbit_o} !== {1'b1, bits[i]}) begin
        bad++;
        $display("FAIL midreset_bit[%0d]: got %b want %b", i, {en_o, rbit_o}, {1'b1, bits[i]});
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if ({busy, done, sent_cnt} !== {2'b01, 8'd8}) begin
      bad++;
      $display("FAIL midreset_done: got %b want %b", {busy, done, sent_cnt}, {2'b01, 8'd8});
    end
  endtask

  task automatic test_zero_len();
    pulse_start(8'd0);
`ifdef CRUMB_SEQ_CONT_EN
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, busy} !== 2'b11) begin
        bad++;
        $display("FAIL cont_run[%0d]: got %b want %b", i, {en_o, busy}, 2'b11);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({en_o, busy, sent_cnt} !== {2'b01, 8'd44}) begin
      bad++;
      $display("FAIL cont_stop: got %b want %b", {en_o, busy, sent_cnt}, {2'b01, 8'd44});
    end
    repeat (5) @(negedge clk);
    total++;
    if ({busy, done, sent_cnt} !== {2'b01, 8'd44}) begin
      bad++;
      $display("FAIL cont_done: got %b want %b", {busy, done, sent_cnt}, {2'b01, 8'd44});
    end
`else
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({en_o, busy, done, sent_cnt} !== {3'b001, 8'd8}) begin
        bad++;
        $display("FAIL zero_len[%0d]: got %b want %b", i, {en_o, busy, done, sent_cnt},
                 {3'b001, 8'd8});
      end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_cmds();
    logic [7:0] hi = 8'hAC;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stop = 1'b1;
    pulse_start(8'd5);
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({en_o, busy, done, sent_cnt} !== 11'h000) begin
        bad++;
        $display("FAIL startstop_idle[%0d]: got %b want %b", i, {en_o, busy, done, sent_cnt},
                 11'h000);
      end
      @(negedge clk);
    end
    pulse_start(8'd8);
    repeat (13) @(negedge clk);
    total++;
    if ({busy, done, sent_cnt} !== {2'b01, 8'd8}) begin
      bad++;
      $display("FAIL cmds_prep_done: got %b want %b", {busy, done, sent_cnt}, {2'b01, 8'd8});
    end
    // Zero seed together with start: the running LFSR must carry on, not reload.
    seed = 16'h0000;
    seed_we = 1'b1;
    pulse_start(8'd8);
    seed_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({en_o, rbit_o} !== {1'b1, hi[i]}) begin
        bad++;
        $display("FAIL startseed_bit[%0d]: got %b want %b", i, {en_o, rbit_o}, {1'b1, hi[i]});
      end
    end
    pulse_start(8'd3);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({en_o, busy, done} !== 3'b010) begin
        bad++;
        $display("FAIL drain_start[%0d]: got %b want %b", i, {en_o, busy, done}, 3'b010);
      end
      @(negedge clk);
    end
    total++;
    if ({en_o, busy, done, sent_cnt} !== {3'b001, 8'd8}) begin
      bad++;
      $display("FAIL drain_start_done: got %b want %b", {en_o, busy, done, sent_cnt},
               {3'b001, 8'd8});
    end
    @(negedge clk);
    total++;
    if ({en_o, busy, done} !== 3'b001) begin
      bad++;
      $display("FAIL drain_start_after: got %b want %b", {en_o, busy, done}, 3'b001);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed();
    test_stop();
    test_reset_mid();
    test_zero_len();
    test_cmds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
